// File: rtl/spi_frame_pkg.sv
// Shared definitions for the host-side SPI master: command opcodes, frame layout,
// readback header constant and the controller state encoding.
package spi_frame_pkg;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_START = 2'b11;

    localparam logic [7:0] RD_HDR = 8'h0F;

    localparam int FRAME_W   = 72;
    localparam int BIT_CNT_W = 7;
    localparam int WAIT_W    = 16;

    localparam int HDR_MSB  = 71;
    localparam int HDR_LSB  = 64;
    localparam int ADDR_MSB = 63;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TX,
        ST_HOLD,
        ST_GAP,
        ST_RDW,
        ST_RX,
        ST_RESP
    } state_t;

    // Only writes carry a payload; read/start send a zero data field.
    function automatic logic [FRAME_W-1:0] buildFrame(input logic [1:0]  op,
                                                      input logic [31:0] addr,
                                                      input logic [31:0] data);
        logic [31:0] payload;
        payload = (op == OP_WRITE) ? data : 32'h0;
        return {6'b0, op, addr, payload};
    endfunction

endpackage

// File: rtl/spi_host_master_sclk_gen.sv
// sclk generator: CLK_DIV clk low phase then CLK_DIV clk high phase per bit while enabled.
// sample_o marks the last low-phase clk, fall_o the last high-phase clk (bit complete).
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic sclk_o,
    output logic sample_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] divCnt_q, divCnt_d;
    logic          phase_q, phase_d;
    logic          lastClk;

    assign lastClk = (divCnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        divCnt_d = divCnt_q;
        phase_d  = phase_q;
        if (!en_i) begin
            divCnt_d = '0;
            phase_d  = 1'b0;
        end else if (lastClk) begin
            divCnt_d = '0;
            phase_d  = ~phase_q;
        end else begin
            divCnt_d = divCnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            divCnt_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            phase_q  <= phase_d;
        end
    end

    assign sclk_o   = en_i & phase_q;
    assign sample_o = en_i & ~phase_q & lastClk;
    assign fall_o   = en_i & phase_q & lastClk;

endmodule

// File: rtl/spi_host_master.sv
// Host-side SPI master: sends 72-bit {op,addr,data} frames and, for reads, clocks back
// the slave's 72-bit readback frame. Optional readback check: define SPI_RD_CHECK_EN.
module spi_host_master
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 8,
    parameter int RD_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        sclk_o,
    output logic        cs_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    // Without the header/address check only the data field of the readback is needed.
`ifdef SPI_RD_CHECK_EN
    localparam int RX_W = FRAME_W;
`else
    localparam int RX_W = DATA_MSB + 1;
`endif

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [FRAME_W-1:0]   txShift_q;
    logic [RX_W-1:0]      rxShift_q;
    logic [BIT_CNT_W-1:0] bitCnt_q;
    logic [WAIT_W-1:0]    waitCnt_q;
    logic [WAIT_W-1:0]    waitLimit;
    logic [31:0]          rspData_q;
    logic                 rspErr_q;
    logic                 rstDone_q;
    logic [31:0]          respData;
    logic                 respErr;
    logic                 rdCheckErr;
    logic                 cmdAccept;
    logic                 lastBit;
    logic                 waitDone;
    logic                 genEn;
    logic                 genSclk;
    logic                 genSample;
    logic                 genFall;

`ifdef SPI_RD_CHECK_EN
    logic [31:0]          addr_q;
    assign rdCheckErr = (rxShift_q[HDR_MSB:HDR_LSB] != RD_HDR) ||
                        (rxShift_q[ADDR_MSB:ADDR_LSB] != addr_q);
`else
    assign rdCheckErr = 1'b0;
`endif

    assign cmdAccept = cmd_valid_i && cmd_ready_o;
    assign lastBit   = (bitCnt_q == BIT_CNT_W'(FRAME_W - 1));
    assign waitLimit = (state_q == ST_RDW) ? WAIT_W'(RD_WAIT - 1) : WAIT_W'(GAP_CYC - 1);
    assign waitDone  = (waitCnt_q == waitLimit);
    assign genEn     = (state_q == ST_TX) || (state_q == ST_RX);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (genEn),
        .sclk_o   (genSclk),
        .sample_o (genSample),
        .fall_o   (genFall)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmdAccept) state_d = (cmd_op_i == OP_NONE) ? ST_RESP : ST_SETUP;
            ST_SETUP: state_d = ST_TX;
            ST_TX:    if (genFall && lastBit) state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_GAP;
            ST_GAP:   if (waitDone) state_d = (op_q == OP_READ) ? ST_RDW : ST_RESP;
            ST_RDW:   if (waitDone) state_d = ST_RX;
            ST_RX:    if (genFall && lastBit) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_o        = 1'b1;
        sclk_o      = 1'b0;
        mosi_o      = 1'b0;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE:  cmd_ready_o = rstDone_q;
            ST_SETUP, ST_HOLD: begin
                cs_o   = 1'b0;
                mosi_o = txShift_q[FRAME_W-1];
            end
            ST_TX: begin
                cs_o   = 1'b0;
                sclk_o = genSclk;
                mosi_o = txShift_q[FRAME_W-1];
            end
            ST_RX:    sclk_o = genSclk;
            ST_RESP:  rsp_valid_o = 1'b1;
            default:  cs_o = 1'b1;
        endcase
    end

    // The only way into RESP straight from IDLE is an illegal op.
    always_comb begin
        respData = '0;
        respErr  = 1'b0;
        if (state_q == ST_IDLE) begin
            respErr = 1'b1;
        end else if (state_q == ST_RX) begin
            respData = rxShift_q[DATA_MSB:DATA_LSB];
            respErr  = rdCheckErr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            op_q      <= OP_NONE;
            txShift_q <= '0;
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            waitCnt_q <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
            rstDone_q <= 1'b0;
`ifdef SPI_RD_CHECK_EN
            addr_q    <= '0;
`endif
        end else begin
            rstDone_q <= 1'b1;
            if (cmdAccept) begin
                op_q      <= cmd_op_i;
                txShift_q <= buildFrame(cmd_op_i, cmd_addr_i, cmd_data_i);
                rxShift_q <= '0;
`ifdef SPI_RD_CHECK_EN
                addr_q    <= cmd_addr_i;
`endif
            end
            if (state_q == ST_TX && genFall) begin
                txShift_q <= {txShift_q[FRAME_W-2:0], 1'b0};
            end
            if (state_q == ST_RX && genSample) begin
                rxShift_q <= {rxShift_q[RX_W-2:0], miso_i};
            end
            if (genFall) begin
                bitCnt_q <= lastBit ? '0 : bitCnt_q + BIT_CNT_W'(1);
            end
            if (state_q == ST_GAP || state_q == ST_RDW) begin
                waitCnt_q <= waitDone ? '0 : waitCnt_q + WAIT_W'(1);
            end
            if (state_d == ST_RESP && state_q != ST_RESP) begin
                rspData_q <= respData;
                rspErr_q  <= respErr;
            end else if (state_q == ST_RESP && rsp_ready_i) begin
                rspData_q <= '0;
                rspErr_q  <= 1'b0;
            end
        end
    end

    assign rsp_data_o = rspData_q;
    assign rsp_err_o  = rspErr_q;

endmodule
